// File: rtl/mor1kx_icache_refill_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module  : mor1kx_icache_refill_ctrl_if
// Purpose : Bundles the icache refill handshake, the icache write port and
//           the instruction-bus signals of the icache refill controller.
// Rev     : 1.0 - initial release
// ============================================================================
interface mor1kx_icache_refill_ctrl_if #(
    parameter int OW = 32
);
    logic          refill_req_i;
    logic [OW-1:0] refill_adr_i;
    logic [OW-1:0] wradr_o;
    logic [OW-1:0] wrdat_o;
    logic          we_o;
    logic          refill_busy_o;
    logic          refill_err_o;
    logic          ibus_req_o;
    logic [OW-1:0] ibus_adr_o;
    logic          ibus_burst_o;
    logic          ibus_ack_i;
    logic          ibus_err_i;
    logic [OW-1:0] ibus_dat_i;

    // The refill controller side.
    modport master (
        input  refill_req_i, refill_adr_i, ibus_ack_i, ibus_err_i, ibus_dat_i,
        output wradr_o, wrdat_o, we_o, refill_busy_o, refill_err_o,
        output ibus_req_o, ibus_adr_o, ibus_burst_o
    );

    // The icache / bus side that talks to the controller.
    modport slave (
        output refill_req_i, refill_adr_i, ibus_ack_i, ibus_err_i, ibus_dat_i,
        input  wradr_o, wrdat_o, we_o, refill_busy_o, refill_err_o,
        input  ibus_req_o, ibus_adr_o, ibus_burst_o
    );
endinterface
`default_nettype wire

// File: rtl/mor1kx_icache_refill_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : mor1kx_icache_refill_ctrl
// Purpose : Refills one icache line over the ibus as a wrapping,
//           critical-word-first burst, forwarding each beat to the icache.
// Rev     : 1.0 - initial release
// ============================================================================
module mor1kx_icache_refill_ctrl #(
    parameter int OPTION_OPERAND_WIDTH      = 32,
    parameter int OPTION_ICACHE_BLOCK_WIDTH = 5
) (
    input  wire logic                      clk,
    input  wire logic                      rst,
    mor1kx_icache_refill_ctrl_if.master    bus
);
    localparam int OW    = OPTION_OPERAND_WIDTH;
    localparam int BW    = OPTION_ICACHE_BLOCK_WIDTH;
    localparam int CW    = BW - 2;
    localparam int WORDS = 1 << CW;
    localparam logic [CW-1:0] c_LAST = CW'(WORDS - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_BURST = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t        r_state, w_state_nxt;
    logic [OW-1:0] r_adr,   w_adr_nxt;
    logic [CW-1:0] r_cnt,   w_cnt_nxt;
    logic          r_err,   w_err_nxt;
    logic          w_in_burst;
    logic          w_unused;

    assign w_unused   = &{1'b0, bus.refill_adr_i[1:0]};
    assign w_in_burst = (r_state == S_BURST);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_adr   <= '0;
            r_cnt   <= '0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_adr   <= w_adr_nxt;
            r_cnt   <= w_cnt_nxt;
            r_err   <= w_err_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_adr_nxt   = r_adr;
        w_cnt_nxt   = r_cnt;
        w_err_nxt   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.refill_req_i) begin
                    w_adr_nxt   = {bus.refill_adr_i[OW-1:2], 2'b00};
                    w_cnt_nxt   = '0;
                    w_state_nxt = S_BURST;
                end
            end
            S_BURST: begin
                if (bus.ibus_err_i) begin
                    w_err_nxt   = 1'b1;
                    w_state_nxt = S_DRAIN;
                end else if (bus.ibus_ack_i) begin
                    w_cnt_nxt = r_cnt + CW'(1);
                    // The final beat keeps its address so wradr_o still
                    // names the last written word while the icache finishes.
                    if (r_cnt == c_LAST) begin
                        w_state_nxt = S_DRAIN;
                    end else begin
                        w_adr_nxt = {r_adr[OW-1:BW], r_adr[BW-1:2] + CW'(1), 2'b00};
                    end
                end
            end
            S_DRAIN: begin
                if (!bus.refill_req_i) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign bus.ibus_req_o    = w_in_burst;
    assign bus.ibus_adr_o    = r_adr;
    assign bus.ibus_burst_o  = w_in_burst && (r_cnt != c_LAST);
    assign bus.refill_busy_o = w_in_burst;
    assign bus.refill_err_o  = r_err;
    assign bus.we_o          = w_in_burst && bus.ibus_ack_i && !bus.ibus_err_i;
    assign bus.wradr_o       = r_adr;
    assign bus.wrdat_o       = bus.ibus_dat_i;
endmodule
`default_nettype wire
